hog_axil_ctrl_regs: RTL and testbench



---
 rtl/hog_axil_ctrl_regs_if.sv | 51 +++++
 rtl/hog_axil_ctrl_regs.sv | 189 ++++++++++++++++++
 tb/tb_hog_axil_ctrl_regs.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hog_axil_ctrl_regs_if.sv
// AXI4-Lite slave bus bundle for the HOG control register bank.
interface hog_axil_ctrl_regs_if #(
   parameter int C_S_AXI_GP_DATA_WIDTH = 32,
   parameter int C_S_AXI_GP_ADDR_WIDTH = 5
);
   logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_awaddr;
   logic [2:0]                         s_axi_awprot;
   logic                               s_axi_awvalid;
   logic                               s_axi_awready;
   logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_wdata;
   logic [C_S_AXI_GP_DATA_WIDTH/8-1:0] s_axi_wstrb;
   logic                               s_axi_wvalid;
   logic                               s_axi_wready;
   logic [1:0]                         s_axi_bresp;
   logic                               s_axi_bvalid;
   logic                               s_axi_bready;
   logic [C_S_AXI_GP_ADDR_WIDTH-1:0]   s_axi_araddr;
   logic [2:0]                         s_axi_arprot;
   logic                               s_axi_arvalid;
   logic                               s_axi_arready;
   logic [C_S_AXI_GP_DATA_WIDTH-1:0]   s_axi_rdata;
   logic [1:0]                         s_axi_rresp;
   logic                               s_axi_rvalid;
   logic                               s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_rready
   );

   modport master (
      output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_rready
   );
endinterface

// File: rtl/hog_axil_ctrl_regs.sv
// HOG accelerator control/status register bank behind the GP AXI4-Lite port.
// Eight word registers: start, image dimensions, HP base addresses, status
// (busy, sticky done/start_err) and interrupt enable.
module hog_axil_ctrl_regs #(
   parameter int C_S_AXI_GP_DATA_WIDTH = 32,
   parameter int C_S_AXI_GP_ADDR_WIDTH = 5,
   parameter int DIM_WIDTH             = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   hog_axil_ctrl_regs_if.slave  s_axi,
   output logic                 start_o,
   output logic [DIM_WIDTH-1:0] width_o,
   output logic [DIM_WIDTH-1:0] height_o,
   output logic [31:0]          src_base_o,
   output logic [31:0]          dst_base_o,
   input  logic                 busy_i,
   input  logic                 done_i,
   output logic                 irq_o
);
   localparam int DW       = C_S_AXI_GP_DATA_WIDTH;
   localparam int SW       = DW / 8;
   localparam int ADDR_LSB = 2;
   localparam int IDX_W    = C_S_AXI_GP_ADDR_WIDTH - ADDR_LSB;

   localparam logic [IDX_W-1:0] REG_CTRL   = IDX_W'(0);
   localparam logic [IDX_W-1:0] REG_WIDTH  = IDX_W'(1);
   localparam logic [IDX_W-1:0] REG_HEIGHT = IDX_W'(2);
   localparam logic [IDX_W-1:0] REG_SRC    = IDX_W'(3);
   localparam logic [IDX_W-1:0] REG_DST    = IDX_W'(4);
   localparam logic [IDX_W-1:0] REG_STATUS = IDX_W'(5);
   localparam logic [IDX_W-1:0] REG_IRQEN  = IDX_W'(6);
   localparam logic [IDX_W-1:0] REG_RSVD   = IDX_W'(7);

   // Expand byte lane enables into a per-bit write mask.
   function automatic logic [DW-1:0] f_strb_mask(input logic [SW-1:0] strb);
      logic [DW-1:0] mask;
      mask = '0;
      for (int i = 0; i < SW; i++) mask[8*i +: 8] = {8{strb[i]}};
      return mask;
   endfunction

   logic                 r_aw_full, r_w_full, r_bvalid, r_rvalid;
   logic [IDX_W-1:0]     r_aw_idx;
   logic [DW-1:0]        r_w_data, r_rdata;
   logic [SW-1:0]        r_w_strb;
   logic [1:0]           r_bresp;
   logic [DIM_WIDTH-1:0] r_width, r_height;
   logic [31:0]          r_src, r_dst;
   logic                 r_irq_en, r_done, r_start_err, r_start_pend, r_start, r_irq;

   logic          w_awready, w_wready, w_arready;
   logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_start_req;
   logic [DW-1:0] w_wmask, w_rd_data;
   logic          w_unused;

   // Readies are forced low while reset is held so every output reads 0.
   assign w_awready = !rst && !r_aw_full && !r_bvalid;
   assign w_wready  = !rst && !r_w_full && !r_bvalid;
   assign w_arready = !rst && !r_rvalid;
   assign w_aw_hs   = s_axi.s_axi_awvalid && w_awready;
   assign w_w_hs    = s_axi.s_axi_wvalid && w_wready;
   assign w_ar_hs   = s_axi.s_axi_arvalid && w_arready;
   assign w_commit  = r_aw_full && r_w_full;
   assign w_wmask   = f_strb_mask(r_w_strb);
   assign w_start_req = w_commit && (r_aw_idx == REG_CTRL) && r_w_data[0] && r_w_strb[0];
   assign w_unused  = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                        s_axi.s_axi_awaddr[ADDR_LSB-1:0], s_axi.s_axi_araddr[ADDR_LSB-1:0]};

   // Independent single-entry AW and W buffers; commit retires both and raises bvalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aw_full <= 1'b0;
         r_aw_idx  <= '0;
         r_w_full  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= s_axi.s_axi_awaddr[C_S_AXI_GP_ADDR_WIDTH-1:ADDR_LSB];
         end else if (w_commit) begin
            r_aw_full <= 1'b0;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= s_axi.s_axi_wdata;
            r_w_strb <= s_axi.s_axi_wstrb;
         end else if (w_commit) begin
            r_w_full <= 1'b0;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (r_aw_idx == REG_RSVD) ? 2'b10 : 2'b00;
         end else if (s_axi.s_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Byte-masked update of the read/write configuration registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_width  <= '0;
         r_height <= '0;
         r_src    <= '0;
         r_dst    <= '0;
         r_irq_en <= 1'b0;
      end else if (w_commit) begin
         if (r_aw_idx == REG_WIDTH)
            r_width <= (r_width & ~w_wmask[DIM_WIDTH-1:0]) | (r_w_data[DIM_WIDTH-1:0] & w_wmask[DIM_WIDTH-1:0]);
         if (r_aw_idx == REG_HEIGHT)
            r_height <= (r_height & ~w_wmask[DIM_WIDTH-1:0]) | (r_w_data[DIM_WIDTH-1:0] & w_wmask[DIM_WIDTH-1:0]);
         if (r_aw_idx == REG_SRC)
            r_src <= (r_src & ~w_wmask[31:0]) | (r_w_data[31:0] & w_wmask[31:0]);
         if (r_aw_idx == REG_DST)
            r_dst <= (r_dst & ~w_wmask[31:0]) | (r_w_data[31:0] & w_wmask[31:0]);
         if (r_aw_idx == REG_IRQEN && r_w_strb[0])
            r_irq_en <= r_w_data[0];
      end
   end

   // Start pulse one edge after commit, sticky status bits (set beats W1C), registered irq.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_start_pend <= 1'b0;
         r_start      <= 1'b0;
         r_start_err  <= 1'b0;
         r_done       <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_start_pend <= w_start_req && !busy_i;
         r_start      <= r_start_pend;
         if (w_start_req && busy_i)
            r_start_err <= 1'b1;
         else if (w_commit && r_aw_idx == REG_STATUS && r_w_strb[0] && r_w_data[2])
            r_start_err <= 1'b0;
         if (done_i)
            r_done <= 1'b1;
         else if (w_commit && r_aw_idx == REG_STATUS && r_w_strb[0] && r_w_data[1])
            r_done <= 1'b0;
         r_irq <= r_done && r_irq_en;
      end
   end

   // Read data mux on the incoming AR address; registers hold pre-write values this cycle.
   always_comb begin
      w_rd_data = '0;
      case (s_axi.s_axi_araddr[C_S_AXI_GP_ADDR_WIDTH-1:ADDR_LSB])
         REG_WIDTH:  w_rd_data = DW'(r_width);
         REG_HEIGHT: w_rd_data = DW'(r_height);
         REG_SRC:    w_rd_data = DW'(r_src);
         REG_DST:    w_rd_data = DW'(r_dst);
         REG_STATUS: w_rd_data = DW'({r_start_err, r_done, busy_i});
         REG_IRQEN:  w_rd_data = DW'(r_irq_en);
         default:    w_rd_data = '0;
      endcase
   end

   // Read channel: capture on AR handshake, hold until rready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
      end else if (s_axi.s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   assign s_axi.s_axi_awready = w_awready;
   assign s_axi.s_axi_wready  = w_wready;
   assign s_axi.s_axi_bvalid  = r_bvalid;
   assign s_axi.s_axi_bresp   = r_bresp;
   assign s_axi.s_axi_arready = w_arready;
   assign s_axi.s_axi_rvalid  = r_rvalid;
   assign s_axi.s_axi_rdata   = r_rdata;
   assign s_axi.s_axi_rresp   = 2'b00;
   assign start_o    = r_start;
   assign width_o    = r_width;
   assign height_o   = r_height;
   assign src_base_o = r_src;
   assign dst_base_o = r_dst;
   assign irq_o      = r_irq;
endmodule

// File: tb/tb_hog_axil_ctrl_regs.sv
// Bench for the HOG AXI-Lite control register bank: directed scenarios plus
// randomized register traffic against a register-map model.
module tb_hog_axil_ctrl_regs;
   logic        clk = 1'b0;
   logic        rst;
   logic        busy_i, done_i;
   logic        start_o, irq_o;
   logic [15:0] width_o, height_o;
   logic [31:0] src_base_o, dst_base_o;

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   int start_cnt = 0;
   int start_cyc = -1;
   int commit_cyc = 0;

   // Register-map model
   logic [31:0] m_rw [8];
   logic        m_done, m_err, m_irqen;

   hog_axil_ctrl_regs_if ifc ();

   hog_axil_ctrl_regs #(
      .C_S_AXI_GP_DATA_WIDTH (32),
      .C_S_AXI_GP_ADDR_WIDTH (5),
      .DIM_WIDTH             (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_axi      (ifc.slave),
      .start_o    (start_o),
      .width_o    (width_o),
      .height_o   (height_o),
      .src_base_o (src_base_o),
      .dst_base_o (dst_base_o),
      .busy_i     (busy_i),
      .done_i     (done_i),
      .irq_o      (irq_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (start_o === 1'b1) begin
         start_cnt++;
         start_cyc = cyc;
      end
   end

   function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endfunction

   function automatic logic [31:0] bmask(input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
      return m;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] r);
      case (r)
         3'd1, 3'd2, 3'd3, 3'd4: return m_rw[r];
         3'd5:    return {29'd0, m_err, m_done, busy_i};
         3'd6:    return {31'd0, m_irqen};
         default: return 32'd0;
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_rw[i] = 32'd0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_irqen = 1'b0;
   endfunction

   task automatic chk_outputs(input string tag);
      logic [31:0] w, h;
      w = m_rw[1];
      h = m_rw[2];
      chk({tag, "_width_o"}, 32'(width_o), 32'(w[15:0]));
      chk({tag, "_height_o"}, 32'(height_o), 32'(h[15:0]));
      chk({tag, "_src_base_o"}, src_base_o, m_rw[3]);
      chk({tag, "_dst_base_o"}, dst_base_o, m_rw[4]);
      chk({tag, "_irq_o"}, 32'(irq_o), 32'(m_done & m_irqen));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start_o"}, 32'(start_o), 0);
      chk({tag, "_width_o"}, 32'(width_o), 0);
      chk({tag, "_height_o"}, 32'(height_o), 0);
      chk({tag, "_src_base_o"}, src_base_o, 0);
      chk({tag, "_dst_base_o"}, dst_base_o, 0);
      chk({tag, "_irq_o"}, 32'(irq_o), 0);
      chk({tag, "_bvalid"}, 32'(ifc.s_axi_bvalid), 0);
      chk({tag, "_bresp"}, 32'(ifc.s_axi_bresp), 0);
      chk({tag, "_rvalid"}, 32'(ifc.s_axi_rvalid), 0);
      chk({tag, "_rdata"}, ifc.s_axi_rdata, 0);
      chk({tag, "_awready"}, 32'(ifc.s_axi_awready), 0);
      chk({tag, "_wready"}, 32'(ifc.s_axi_wready), 0);
      chk({tag, "_arready"}, 32'(ifc.s_axi_arready), 0);
   endtask

   // lead > 0: W presented lead cycles before AW; lead < 0: AW first; 0: together.
   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdly, input bit pdone, output logic [1:0] resp);
      bit aw_done, w_done, aw_go, w_go;
      int aw_st, w_st;
      aw_done = 1'b0;
      w_done = 1'b0;
      aw_st = (lead > 0) ? lead : 0;
      w_st = (lead < 0) ? -lead : 0;
      @(negedge clk);
      ifc.s_axi_awaddr = a;
      ifc.s_axi_wdata = d;
      ifc.s_axi_wstrb = s;
      for (int t = 0; t < 60 && !(aw_done && w_done); t++) begin
         ifc.s_axi_awvalid = !aw_done && (t >= aw_st);
         ifc.s_axi_wvalid = !w_done && (t >= w_st);
         aw_go = ifc.s_axi_awvalid && ifc.s_axi_awready;
         w_go = ifc.s_axi_wvalid && ifc.s_axi_wready;
         @(posedge clk);
         if (aw_go) aw_done = 1'b1;
         if (w_go) w_done = 1'b1;
         @(negedge clk);
      end
      ifc.s_axi_awvalid = 1'b0;
      ifc.s_axi_wvalid = 1'b0;
      chk("wr_accept", 32'(aw_done && w_done), 1);
      chk("wr_bvalid_before_commit", 32'(ifc.s_axi_bvalid), 0);
      if (pdone) done_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      chk("wr_bvalid_latency", 32'(ifc.s_axi_bvalid), 1);
      commit_cyc = cyc;
      for (int k = 0; k < bdly; k++) begin
         @(negedge clk);
         chk("wr_bvalid_hold", 32'(ifc.s_axi_bvalid), 1);
         chk("wr_awready_blocked", 32'(ifc.s_axi_awready), 0);
         chk("wr_wready_blocked", 32'(ifc.s_axi_wready), 0);
      end
      resp = ifc.s_axi_bresp;
      ifc.s_axi_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.s_axi_bready = 1'b0;
      chk("wr_bvalid_drop", 32'(ifc.s_axi_bvalid), 0);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly, input bit pdone);
      logic [1:0] resp;
      logic [2:0] r;
      logic [31:0] m;
      int sc0;
      bit exp_pulse;
      r = a[4:2];
      m = bmask(s);
      sc0 = start_cnt;
      exp_pulse = 1'b0;
      axi_write(a, d, s, lead, bdly, pdone, resp);
      case (r)
         3'd0: if (d[0] && s[0]) begin
            if (busy_i) m_err = 1'b1;
            else exp_pulse = 1'b1;
         end
         3'd1, 3'd2: m_rw[r] = ((m_rw[r] & ~m) | (d & m)) & 32'h0000_FFFF;
         3'd3, 3'd4: m_rw[r] = (m_rw[r] & ~m) | (d & m);
         3'd5: if (s[0]) begin
            if (d[1]) m_done = 1'b0;
            if (d[2]) m_err = 1'b0;
         end
         3'd6: if (s[0]) m_irqen = d[0];
         default: ;
      endcase
      if (pdone) m_done = 1'b1;
      chk("wr_bresp", 32'(resp), (r == 3'd7) ? 32'd2 : 32'd0);
      @(negedge clk);
      chk("start_pulse_count", 32'(start_cnt - sc0), 32'(exp_pulse));
      if (exp_pulse) chk("start_pulse_cycle", 32'(start_cyc), 32'(commit_cyc + 1));
      chk_outputs("post_wr");
   endtask

   task automatic do_read(input logic [4:0] a, output logic [31:0] rd);
      int t;
      @(negedge clk);
      ifc.s_axi_araddr = a;
      ifc.s_axi_arvalid = 1'b1;
      t = 0;
      while (!ifc.s_axi_arready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rd_arready", 32'(ifc.s_axi_arready), 1);
      @(posedge clk);
      @(negedge clk);
      ifc.s_axi_arvalid = 1'b0;
      chk("rd_rvalid_latency", 32'(ifc.s_axi_rvalid), 1);
      rd = ifc.s_axi_rdata;
      chk("rd_rdata", rd, model_read(a[4:2]));
      chk("rd_rresp", 32'(ifc.s_axi_rresp), 0);
      @(negedge clk);
      chk("rd_rvalid_hold", 32'(ifc.s_axi_rvalid), 1);
      chk("rd_rdata_hold", ifc.s_axi_rdata, rd);
      ifc.s_axi_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.s_axi_rready = 1'b0;
      chk("rd_rvalid_drop", 32'(ifc.s_axi_rvalid), 0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [2:0]  r;
      rst = 1'b1;
      busy_i = 1'b0;
      done_i = 1'b0;
      ifc.s_axi_awaddr = '0;
      ifc.s_axi_awprot = '0;
      ifc.s_axi_awvalid = 1'b0;
      ifc.s_axi_wdata = '0;
      ifc.s_axi_wstrb = '0;
      ifc.s_axi_wvalid = 1'b0;
      ifc.s_axi_bready = 1'b0;
      ifc.s_axi_araddr = '0;
      ifc.s_axi_arprot = '0;
      ifc.s_axi_arvalid = 1'b0;
      ifc.s_axi_rready = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_awready", 32'(ifc.s_axi_awready), 1);
      chk("post_reset_wready", 32'(ifc.s_axi_wready), 1);
      chk("post_reset_arready", 32'(ifc.s_axi_arready), 1);

      // Image dimensions: AW/W together, then W three cycles ahead of AW
      do_write(5'h04, 32'h0000_0280, 4'hF, 0, 0, 1'b0);
      do_write(5'h08, 32'h0000_01E0, 4'hF, 3, 0, 1'b0);
      chk("width_640", 32'(width_o), 32'd640);
      chk("height_480", 32'(height_o), 32'd480);
      do_read(5'h04, rd);
      chk("width_readback", rd, 32'h0000_0280);
      do_read(5'h08, rd);
      chk("height_readback", rd, 32'h0000_01E0);
      do_write(5'h0A, 32'hABCD_01E0, 4'hF, -2, 0, 1'b0);
      do_read(5'h08, rd);
      chk("height_upper_discarded", rd, 32'h0000_01E0);

      // Byte strobes and back-pressure on the write response
      do_write(5'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0);
      do_write(5'h0C, 32'h0000_0000, 4'b0010, 1, 5, 1'b0);
      do_read(5'h0C, rd);
      chk("src_strobe_readback", rd, 32'hFFFF_00FF);

      // Start pulse, then start while busy
      busy_i = 1'b0;
      do_write(5'h00, 32'h1, 4'h1, 0, 0, 1'b0);
      do_read(5'h00, rd);
      chk("ctrl_reads_zero", rd, 32'h0);
      busy_i = 1'b1;
      do_write(5'h00, 32'h1, 4'h1, 0, 0, 1'b0);
      do_read(5'h14, rd);
      chk("status_busy_err", rd, 32'h5);
      busy_i = 1'b0;

      // Done, irq, W1C, and W1C losing to a coincident done
      do_write(5'h18, 32'h1, 4'h1, 0, 0, 1'b0);
      @(negedge clk);
      done_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      m_done = 1'b1;
      chk("irq_lags_done", 32'(irq_o), 0);
      @(negedge clk);
      chk("irq_after_done", 32'(irq_o), 1);
      do_read(5'h14, rd);
      chk("status_done_set", rd, 32'h6);
      do_write(5'h14, 32'h2, 4'h1, 0, 0, 1'b0);
      chk("irq_cleared", 32'(irq_o), 0);
      do_read(5'h14, rd);
      chk("status_done_cleared", rd, 32'h4);
      do_write(5'h14, 32'h2, 4'h1, 0, 0, 1'b1);
      do_read(5'h14, rd);
      chk("status_done_set_wins", rd, 32'h6);
      do_write(5'h14, 32'h6, 4'h2, 0, 0, 1'b0);
      do_write(5'h14, 32'h6, 4'h1, 0, 0, 1'b0);

      // Randomized register traffic
      for (int i = 0; i < 40; i++) begin
         r = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 1) == 1)
            do_write({r, 2'($urandom)}, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                     int'($urandom_range(0, 2)), 1'b0);
         else
            do_read({r, 2'($urandom)}, rd);
      end

      // Reserved word
      do_write(5'h1C, $urandom, 4'hF, 0, 0, 1'b0);
      for (int i = 0; i < 8; i++) do_read(5'(i * 4), rd);
      do_read(5'h1F, rd);
      chk("reserved_reads_zero", rd, 32'h0);

      // Reset while a write response is pending
      do_write(5'h18, 32'h1, 4'h1, 0, 0, 1'b0);
      do_write(5'h10, 32'h1234_5678, 4'hF, 0, 0, 1'b1);
      do_write(5'h04, 32'h0000_0140, 4'hF, 0, 0, 1'b0);
      @(negedge clk);
      ifc.s_axi_awaddr = 5'h08;
      ifc.s_axi_wdata = 32'h0000_00F0;
      ifc.s_axi_wstrb = 4'hF;
      ifc.s_axi_awvalid = 1'b1;
      ifc.s_axi_wvalid = 1'b1;
      @(negedge clk);
      ifc.s_axi_awvalid = 1'b0;
      ifc.s_axi_wvalid = 1'b0;
      @(negedge clk);
      chk("pending_bvalid", 32'(ifc.s_axi_bvalid), 1);
      chk("pending_irq", 32'(irq_o), 1);
      #2 rst = 1'b1;
      #1 chk_all_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("after_reset_bvalid", 32'(ifc.s_axi_bvalid), 0);
      for (int i = 1; i < 7; i++) do_read(5'(i * 4), rd);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
